alu_rs_queue: RTL and testbench

- Parametrised ALU reservation station: DEPTH entries, NUM_CDB common-data-bus wakeup ports, oldest-first select, registered issue stage.
- Sits between dispatch/rename and the ALU functional unit.
- Holds instructions until both operands are valid, then issues one per cycle when the ALU signals availability.

---
 rtl/alu_rs_queue.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_rs_queue.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_queue.sv
// ALU reservation station: DEPTH entries, NUM_CDB wakeup ports, one registered issue per cycle.
// Latency: ready dispatch or last CDB wakeup to issueValid is 2 edges (no same-cycle wakeup-to-select).
// Backpressure: full/freeCount stall dispatch (alloc while full is dropped); execute=0 holds issue.
// Build option ALU_RS_AGE_SELECT_EN: oldest-first select via age matrix; otherwise lowest index first.
module alu_rs_queue #(
  parameter int WIDTH   = 32,
  parameter int ROB_W   = 3,
  parameter int CTRL_W  = 4,
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       globalResetN,
  input  logic                       clear,
  input  logic                       allocValid,
  input  logic                       allocReady1,
  input  logic                       allocReady2,
  input  logic [WIDTH-1:0]           allocValue1,
  input  logic [WIDTH-1:0]           allocValue2,
  input  logic [ROB_W-1:0]           allocTag1,
  input  logic [ROB_W-1:0]           allocTag2,
  input  logic [ROB_W-1:0]           allocRob,
  input  logic [CTRL_W-1:0]          allocCtrl,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] freeCount,
  output logic [DEPTH-1:0]           busy,
  input  logic [NUM_CDB-1:0]         cdbValid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdbTag,
  input  logic [NUM_CDB*WIDTH-1:0]   cdbValue,
  input  logic                       execute,
  output logic                       issueValid,
  output logic [WIDTH-1:0]           issueSrc1,
  output logic [WIDTH-1:0]           issueSrc2,
  output logic [ROB_W-1:0]           issueRob,
  output logic [CTRL_W-1:0]          issueCtrl
);

  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic              rdy1;
    logic [WIDTH-1:0]  val1;
    logic [ROB_W-1:0]  tag1;
    logic              rdy2;
    logic [WIDTH-1:0]  val2;
    logic [ROB_W-1:0]  tag2;
    logic [ROB_W-1:0]  rob;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Returns {hit, value}; scanning high to low lets the lowest matching port win.
  function automatic logic [WIDTH:0] cdb_lookup(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*ROB_W-1:0] tags,
    input logic [NUM_CDB*WIDTH-1:0] vals
  );
    logic [WIDTH:0] res;
    res = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*ROB_W +: ROB_W] == tag)) begin
        res = {1'b1, vals[p*WIDTH +: WIDTH]};
      end
    end
    return res;
  endfunction

  entry_t            r_ent [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic              r_iss_vld;
  logic [WIDTH-1:0]  r_iss_src1;
  logic [WIDTH-1:0]  r_iss_src2;
  logic [ROB_W-1:0]  r_iss_rob;
  logic [CTRL_W-1:0] r_iss_ctrl;

  entry_t            w_upd [DEPTH];
  logic [WIDTH:0]    w_lk1 [DEPTH];
  logic [WIDTH:0]    w_lk2 [DEPTH];
  entry_t            w_new_ent;
  logic [WIDTH:0]    w_alk1;
  logic [WIDTH:0]    w_alk2;
  entry_t            w_sel_ent;
  logic [DEPTH-1:0]  w_elig;
  logic [DEPTH-1:0]  w_sel_oh;
  logic              w_sel_fire;
  logic              w_alloc_fire;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic [FC_W-1:0]   w_free_cnt;

  // Status outputs come straight from registered entry state.
  assign full         = (w_free_cnt == '0);
  assign freeCount    = w_free_cnt;
  assign busy         = r_vld;
  assign w_alloc_fire = allocValid & ~full;
  assign w_sel_fire   = execute & (|w_sel_oh);

  assign issueValid = r_iss_vld;
  assign issueSrc1  = r_iss_src1;
  assign issueSrc2  = r_iss_src2;
  assign issueRob   = r_iss_rob;
  assign issueCtrl  = r_iss_ctrl;

  // Free-entry count and lowest-index free slot for the next alloc.
  always_comb begin
    w_free_cnt  = '0;
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free_cnt  = w_free_cnt + FC_W'(1);
        w_alloc_idx = IDX_W'(i);
      end
    end
  end

  // Wakeup: waiting operands capture a matching CDB broadcast; ready operands are left alone.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_upd[i] = r_ent[i];
      w_lk1[i] = cdb_lookup(r_ent[i].tag1, cdbValid, cdbTag, cdbValue);
      w_lk2[i] = cdb_lookup(r_ent[i].tag2, cdbValid, cdbTag, cdbValue);
      if (!r_ent[i].rdy1) begin
        w_upd[i].rdy1 = w_lk1[i][WIDTH];
        w_upd[i].val1 = w_lk1[i][WIDTH-1:0];
      end
      if (!r_ent[i].rdy2) begin
        w_upd[i].rdy2 = w_lk2[i][WIDTH];
        w_upd[i].val2 = w_lk2[i][WIDTH-1:0];
      end
    end
  end

  // New entry, with same-cycle CDB bypass for operands dispatched as not ready.
  always_comb begin
    w_alk1         = cdb_lookup(allocTag1, cdbValid, cdbTag, cdbValue);
    w_alk2         = cdb_lookup(allocTag2, cdbValid, cdbTag, cdbValue);
    w_new_ent      = '0;
    w_new_ent.rdy1 = allocReady1;
    w_new_ent.val1 = allocValue1;
    w_new_ent.tag1 = allocTag1;
    w_new_ent.rdy2 = allocReady2;
    w_new_ent.val2 = allocValue2;
    w_new_ent.tag2 = allocTag2;
    w_new_ent.rob  = allocRob;
    w_new_ent.ctrl = allocCtrl;
    if (!allocReady1 && w_alk1[WIDTH]) begin
      w_new_ent.rdy1 = 1'b1;
      w_new_ent.val1 = w_alk1[WIDTH-1:0];
    end
    if (!allocReady2 && w_alk2[WIDTH]) begin
      w_new_ent.rdy2 = 1'b1;
      w_new_ent.val2 = w_alk2[WIDTH-1:0];
    end
  end

  // Eligibility uses registered readiness only, so a wakeup is selectable one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_elig[i] = r_vld[i] & r_ent[i].rdy1 & r_ent[i].rdy2;
    end
  end

`ifdef ALU_RS_AGE_SELECT_EN
  // Row i bit j set means entry i is older than entry j; stale bits of free entries are masked.
  logic [DEPTH-1:0] r_age [DEPTH];

  // Pick the eligible entry older than every other eligible entry.
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel_oh[i] = w_elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_elig[j] && !r_age[i][j]) w_sel_oh[i] = 1'b0;
      end
    end
  end

  // New entry is youngest: its row cleared, its column set in every live row.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (w_alloc_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(i) == w_alloc_idx) r_age[i] <= '0;
        else                          r_age[i][w_alloc_idx] <= r_vld[i];
      end
    end
  end
`else
  // Fixed priority: lowest eligible index.
  always_comb begin
    w_sel_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end
`endif

  // One-hot mux of the selected entry into the issue path.
  always_comb begin
    w_sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel_oh[i]) w_sel_ent = r_ent[i];
    end
  end

  // Entry state: issue frees, alloc fills a free slot (never the issuing one), others wake up.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (clear) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_sel_fire && w_sel_oh[i]) begin
          r_vld[i] <= 1'b0;
        end else if (w_alloc_fire && (w_alloc_idx == IDX_W'(i))) begin
          r_vld[i] <= 1'b1;
          r_ent[i] <= w_new_ent;
        end else if (r_vld[i]) begin
          r_ent[i] <= w_upd[i];
        end
      end
    end
  end

  // Issue registers: load on select, otherwise drop valid and hold data.
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      r_iss_vld  <= 1'b0;
      r_iss_src1 <= '0;
      r_iss_src2 <= '0;
      r_iss_rob  <= '0;
      r_iss_ctrl <= '0;
    end else if (clear) begin
      r_iss_vld  <= 1'b0;
      r_iss_src1 <= '0;
      r_iss_src2 <= '0;
      r_iss_rob  <= '0;
      r_iss_ctrl <= '0;
    end else if (w_sel_fire) begin
      r_iss_vld  <= 1'b1;
      r_iss_src1 <= w_sel_ent.val1;
      r_iss_src2 <= w_sel_ent.val2;
      r_iss_rob  <= w_sel_ent.rob;
      r_iss_ctrl <= w_sel_ent.ctrl;
    end else begin
      r_iss_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rs_queue.sv
// Bench for alu_rs_queue: directed scenarios plus random traffic against a reference model.
// Model keeps entries as plain arrays with a dispatch sequence number for age.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_alu_rs_queue;

  localparam int WIDTH = 32, ROB_W = 3, CTRL_W = 4, DEPTH = 8, NUM_CDB = 2;

  logic        clk = 1'b0;
  logic        globalResetN = 1'b1;
  logic        clear = 1'b0;
  logic        allocValid = 1'b0, allocReady1 = 1'b0, allocReady2 = 1'b0;
  logic [31:0] allocValue1 = '0, allocValue2 = '0;
  logic [2:0]  allocTag1 = '0, allocTag2 = '0, allocRob = '0;
  logic [3:0]  allocCtrl = '0;
  logic        execute = 1'b0;
  logic        cdb_vld [2];
  logic [2:0]  cdb_tag [2];
  logic [31:0] cdb_val [2];
  logic [1:0]  cdbValid;
  logic [5:0]  cdbTag;
  logic [63:0] cdbValue;
  logic        full, issueValid;
  logic [3:0]  freeCount;
  logic [7:0]  busy;
  logic [31:0] issueSrc1, issueSrc2;
  logic [2:0]  issueRob;
  logic [3:0]  issueCtrl;
  logic [84:0] dut_vec;

  assign cdbValid = {cdb_vld[1], cdb_vld[0]};
  assign cdbTag   = {cdb_tag[1], cdb_tag[0]};
  assign cdbValue = {cdb_val[1], cdb_val[0]};
  assign dut_vec  = {full, freeCount, busy, issueValid, issueSrc1, issueSrc2, issueRob, issueCtrl};

  alu_rs_queue #(.WIDTH(WIDTH), .ROB_W(ROB_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .globalResetN(globalResetN), .clear(clear),
    .allocValid(allocValid), .allocReady1(allocReady1), .allocReady2(allocReady2),
    .allocValue1(allocValue1), .allocValue2(allocValue2),
    .allocTag1(allocTag1), .allocTag2(allocTag2), .allocRob(allocRob), .allocCtrl(allocCtrl),
    .full(full), .freeCount(freeCount), .busy(busy),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue),
    .execute(execute), .issueValid(issueValid), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
    .issueRob(issueRob), .issueCtrl(issueCtrl)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state.
  bit          m_v [8];
  bit          m_r1 [8], m_r2 [8];
  logic [31:0] m_x1 [8], m_x2 [8];
  logic [2:0]  m_t1 [8], m_t2 [8], m_rob [8];
  logic [3:0]  m_ctl [8];
  int          m_age [8];
  int          m_seq;
  logic        e_ivld;
  logic [31:0] e_s1, e_s2;
  logic [2:0]  e_rob;
  logic [3:0]  e_ctl;

  function automatic logic [84:0] exp_vec();
    int nfree;
    logic [7:0] b;
    nfree = 0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = m_v[i];
      if (!m_v[i]) nfree++;
    end
    return {(nfree == 0), 4'(nfree), b, e_ivld, e_s1, e_s2, e_rob, e_ctl};
  endfunction

  function automatic logic [32:0] m_cdb(input logic [2:0] tag);
    logic [32:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int p = 0; p < 2; p++) begin
      if (!found && cdb_vld[p] && cdb_tag[p] == tag) begin
        r = {1'b1, cdb_val[p]};
        found = 1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_seq = 0;
    e_ivld = 0; e_s1 = '0; e_s2 = '0; e_rob = '0; e_ctl = '0;
  endtask

  // One clock edge of the reservation station, from the current inputs.
  task automatic model_edge();
    int sel, fr;
    logic [32:0] h;
    if (clear) begin
      model_reset();
    end else begin
      sel = -1;
      fr = -1;
      for (int i = 0; i < 8; i++) begin
        if (execute && m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef ALU_RS_AGE_SELECT_EN
          if (sel < 0 || m_age[i] < m_age[sel]) sel = i;
`else
          if (sel < 0) sel = i;
`endif
        end
        if (!m_v[i] && fr < 0) fr = i;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_v[i] && !m_r1[i]) begin
          h = m_cdb(m_t1[i]);
          if (h[32]) begin m_r1[i] = 1; m_x1[i] = h[31:0]; end
        end
        if (m_v[i] && !m_r2[i]) begin
          h = m_cdb(m_t2[i]);
          if (h[32]) begin m_r2[i] = 1; m_x2[i] = h[31:0]; end
        end
      end
      if (sel >= 0) begin
        e_ivld = 1; e_s1 = m_x1[sel]; e_s2 = m_x2[sel]; e_rob = m_rob[sel]; e_ctl = m_ctl[sel];
        m_v[sel] = 0;
      end else begin
        e_ivld = 0;
      end
      if (allocValid && fr >= 0) begin
        m_v[fr] = 1;
        m_r1[fr] = allocReady1; m_x1[fr] = allocValue1; m_t1[fr] = allocTag1;
        m_r2[fr] = allocReady2; m_x2[fr] = allocValue2; m_t2[fr] = allocTag2;
        if (!allocReady1) begin
          h = m_cdb(allocTag1);
          if (h[32]) begin m_r1[fr] = 1; m_x1[fr] = h[31:0]; end
        end
        if (!allocReady2) begin
          h = m_cdb(allocTag2);
          if (h[32]) begin m_r2[fr] = 1; m_x2[fr] = h[31:0]; end
        end
        m_rob[fr] = allocRob; m_ctl[fr] = allocCtrl;
        m_age[fr] = m_seq;
        m_seq++;
      end
    end
  endtask

  task automatic idle();
    allocValid = 0;
    clear = 0;
    for (int p = 0; p < 2; p++) cdb_vld[p] = 0;
  endtask

  task automatic set_alloc(input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [2:0] t2,
                           input logic [2:0] rob, input logic [3:0] ctl);
    allocValid = 1;
    allocReady1 = r1; allocValue1 = v1; allocTag1 = t1;
    allocReady2 = r2; allocValue2 = v2; allocTag2 = t2;
    allocRob = rob; allocCtrl = ctl;
  endtask

  task automatic set_cdb(input int p, input logic [2:0] tag, input logic [31:0] val);
    cdb_vld[p] = 1; cdb_tag[p] = tag; cdb_val[p] = val;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    idle();
    execute = 0;
    for (int p = 0; p < 2; p++) begin cdb_tag[p] = '0; cdb_val[p] = '0; end
    #2 globalResetN = 0;
    #1 model_reset();
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
    end
    n_chk++;
    if (freeCount !== 4'd8 || full !== 1'b0 || busy !== 8'h00 || issueValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: got fc=%0d full=%b busy=%h iv=%b want fc=8 full=0 busy=00 iv=0",
                         freeCount, full, busy, issueValid);
    end
    @(negedge clk);
    globalResetN = 1;
  endtask

  task automatic test_basic();
    execute = 1;
    set_alloc(1, 5, 0, 1, 7, 0, 3, 0);
    step();
    idle();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b0) begin
      n_fail++; $display("FAIL basic_alloc: got %h want %h", dut_vec, exp_vec());
    end
    step();
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL basic_issue_model: got %h want %h", dut_vec, exp_vec());
    end
    n_chk++;
    if (issueValid !== 1'b1 || issueSrc1 !== 32'd5 || issueSrc2 !== 32'd7 || issueRob !== 3'd3 || freeCount !== 4'd8) begin
      n_fail++; $display("FAIL basic_issue: got iv=%b s1=%0d s2=%0d rob=%0d fc=%0d want 1 5 7 3 8",
                         issueValid, issueSrc1, issueSrc2, issueRob, freeCount);
    end
    step();
    n_chk++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL basic_drain: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fill();
    execute = 0;
    for (int i = 0; i < 9; i++) begin
      set_alloc(0, 0, 2, 1, i, 0, 3'(i), 4'(i));
      step();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL fill_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (full !== 1'b1 || freeCount !== 4'd0 || busy !== 8'hFF) begin
      n_fail++; $display("FAIL fill_full: got full=%b fc=%0d busy=%h want 1 0 ff", full, freeCount, busy);
    end
    idle();
    set_cdb(1, 2, 32'hAA);
    step();
    idle();
    execute = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueSrc1 !== 32'hAA || issueRob !== 3'(i)) begin
        n_fail++; $display("FAIL fill_issue_%0d: got %h want %h (src1 aa, rob %0d)", i, dut_vec, exp_vec(), i);
      end
    end
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b0) begin
      n_fail++; $display("FAIL fill_empty: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_age();
    logic [2:0] first_rob;
    // B eligible first issues before A, which wakes at that same edge.
    execute = 1;
    set_alloc(0, 0, 4, 1, 2, 0, 1, 1);
    step();
    set_alloc(1, 3, 0, 1, 3, 0, 2, 2);
    step();
    idle();
    set_cdb(0, 4, 32'h44);
    step();
    idle();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueRob !== 3'd2) begin
      n_fail++; $display("FAIL age_b_first: got %h want %h (rob 2)", dut_vec, exp_vec());
    end
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueRob !== 3'd1 || issueSrc1 !== 32'h44) begin
      n_fail++; $display("FAIL age_a_second: got %h want %h (rob 1, src1 44)", dut_vec, exp_vec());
    end
    // Older A sits at a higher index than younger B; both wake together.
    execute = 0;
    set_alloc(1, 9, 0, 1, 9, 0, 0, 0);
    step();
    set_alloc(0, 0, 5, 1, 1, 0, 1, 1);
    step();
    idle();
    execute = 1;
    step();
    execute = 0;
    set_alloc(0, 0, 5, 1, 1, 0, 2, 2);
    step();
    idle();
    set_cdb(0, 5, 32'h55);
    step();
    idle();
    execute = 1;
`ifdef ALU_RS_AGE_SELECT_EN
    first_rob = 3'd1;
`else
    first_rob = 3'd2;
`endif
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueRob !== first_rob) begin
      n_fail++; $display("FAIL age_same_cycle: got %h want %h (rob %0d)", dut_vec, exp_vec(), first_rob);
    end
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueRob !== (3'd3 - first_rob)) begin
      n_fail++; $display("FAIL age_same_cycle_2nd: got %h want %h", dut_vec, exp_vec());
    end
    step();
  endtask

  task automatic test_bypass();
    execute = 1;
    set_alloc(0, 0, 6, 1, 9, 0, 4, 5);
    set_cdb(0, 6, 32'h11);
    set_cdb(1, 6, 32'h22);
    step();
    idle();
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueSrc1 !== 32'h11 || issueCtrl !== 4'd5) begin
      n_fail++; $display("FAIL bypass: got %h want %h (src1 11, ctrl 5)", dut_vec, exp_vec());
    end
    set_alloc(1, 1, 0, 0, 0, 3, 6, 7);
    step();
    idle();
    set_cdb(0, 3, 32'h33);
    set_cdb(1, 3, 32'h34);
    step();
    idle();
    step();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueSrc2 !== 32'h33) begin
      n_fail++; $display("FAIL wake_port_prio: got %h want %h (src2 33)", dut_vec, exp_vec());
    end
    step();
  endtask

  task automatic test_stall();
    execute = 0;
    set_alloc(1, 50, 0, 1, 51, 0, 5, 1);
    step();
    set_alloc(1, 60, 0, 1, 61, 0, 6, 2);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || issueValid !== 1'b0 || freeCount !== 4'd6) begin
        n_fail++; $display("FAIL stall_%0d: got %h want %h (iv 0, fc 6)", k, dut_vec, exp_vec());
      end
    end
    execute = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++;
      if (dut_vec !== exp_vec() || issueValid !== 1'b1 || issueRob !== 3'(5 + k)) begin
        n_fail++; $display("FAIL stall_resume_%0d: got %h want %h (rob %0d)", k, dut_vec, exp_vec(), 5 + k);
      end
    end
    step();
  endtask

  task automatic test_clear();
    execute = 0;
    for (int i = 0; i < 5; i++) begin
      set_alloc(1, i, 0, 1, i, 0, 3'(i), 0);
      step();
    end
    set_alloc(1, 8, 0, 1, 8, 0, 7, 0);
    clear = 1;
    execute = 1;
    step();
    idle();
    n_chk++;
    if (dut_vec !== exp_vec() || busy !== 8'h00 || freeCount !== 4'd8 || issueValid !== 1'b0) begin
      n_fail++; $display("FAIL clear: got %h want %h", dut_vec, exp_vec());
    end
    set_alloc(1, 32'h77, 0, 1, 32'h78, 0, 3, 4);
    step();
    idle();
    step();
    #2 globalResetN = 0;
    #1 model_reset();
    n_chk++;
    if (dut_vec !== exp_vec() || issueValid !== 1'b0 || issueSrc1 !== 32'd0 || freeCount !== 4'd8) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    globalResetN = 1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      idle();
      clear = ($urandom_range(0, 63) == 0);
      execute = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 6) begin
        set_alloc($urandom_range(0, 1), $urandom, $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 15));
      end
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1) set_cdb(p, $urandom_range(0, 7), $urandom);
      end
      step();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_age();
    test_bypass();
    test_stall();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
